reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter COUNT_WIDTH, default 16, width of the committed-write counter.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 NReset  input  1  reset; asynchronous, active-low.
REQ-004 ValidA  input  1  requester A (ALU writeback) offers a write.
REQ-005 IdA  input  5  requester A destination register number.
REQ-006 DataA  input  32  requester A write data.
REQ-007 ReadyA  output  1  requester A write accepted this cycle.
REQ-008 ValidB, IdB, DataB, ReadyB  in/in/in/out  1/5/32/1  requester B (load writeback), same meaning as A.
REQ-009 Hold  input  1  blocks all acceptance while 1.
REQ-010 EnableWrite  output  1  register-file write enable.
REQ-011 RegIDToWrite  output  5  register-file write register number.
REQ-012 DataIn  output  32  register-file write data.
REQ-013 WriteCount  output  COUNT_WIDTH  number of committed writes, wraps.
REQ-014 LastGrant  output  1  0 = A granted most recently, 1 = B.

Function
REQ-015 A handshake on requester X SHALL occur on a rising edge where ValidX=1 and ReadyX=1.
REQ-016 ReadyA/ReadyB SHALL be combinational from ValidA, ValidB, Hold, LastGrant; at most one SHALL be 1 per cycle.
REQ-017 Hold=1 SHALL force ReadyA=ReadyB=0.
REQ-018 Only one valid requester (Hold=0): that requester SHALL be granted.
REQ-019 Both valid (Hold=0): grant SHALL go to A when LastGrant=1, to B when LastGrant=0 (round-robin).
REQ-020 Neither valid: ReadyA=ReadyB=0, LastGrant unchanged.
REQ-021 On each handshake LastGrant SHALL update to the granted requester on the same edge.
REQ-022 On handshake, Id/Data of the granted requester SHALL be registered into RegIDToWrite/DataIn on that edge; latency 1 cycle.
REQ-023 EnableWrite SHALL be 1 for exactly the cycle after a handshake whose Id is nonzero, else 0; throughput one write per cycle.
REQ-024 Handshake with Id=0 SHALL complete (Ready=1, LastGrant updates) but EnableWrite SHALL stay 0 and WriteCount SHALL not increment.
REQ-025 RegIDToWrite/DataIn SHALL hold last captured values when no handshake occurs.
REQ-026 WriteCount SHALL increment by 1 on each edge where EnableWrite=1, wrapping from 2^COUNT_WIDTH-1 to 0.
REQ-027 Same Id from both requesters in one cycle: SHALL be serialized per REQ-019; later-granted data is last written.
REQ-028 Hold asserted while a request waits: request SHALL remain pending (no handshake), a previously captured write still completes its EnableWrite cycle.
REQ-029 Requester dropping ValidX without handshake SHALL leave no state change.

Reset
REQ-030 NReset=0 SHALL immediately, independent of Clock, force EnableWrite=0, RegIDToWrite=0, DataIn=0, WriteCount=0, LastGrant=1.
REQ-031 While NReset=0, ReadyA=ReadyB=0.
REQ-032 Reset asserted in the cycle after a handshake SHALL cancel the pending EnableWrite pulse.
REQ-033 After NReset rises, first simultaneous request SHALL be granted to A.

Verification
REQ-034 Reset release, ValidA=1 IdA=5 DataA=0x1234_5678 -> ReadyA=1 same cycle; next cycle EnableWrite=1, RegIDToWrite=5, DataIn=0x1234_5678, then WriteCount=1.
REQ-035 ValidA=ValidB=1 held 4 cycles, IdA=3 IdB=7 -> grants A,B,A,B; EnableWrite=1 four consecutive cycles; RegIDToWrite 3,7,3,7.
REQ-036 ValidB=1 IdB=0 DataB=0xFFFF_FFFF -> ReadyB=1, LastGrant=1, EnableWrite stays 0, WriteCount unchanged.
REQ-037 Hold=1 with both valid for 3 cycles -> ReadyA=ReadyB=0, no EnableWrite; Hold=0 -> grant per LastGrant.
REQ-038 COUNT_WIDTH=4, 17 nonzero writes -> WriteCount reads 1 after the 17th.
REQ-039 NReset pulsed low mid-cycle after a handshake -> outputs zero immediately, no EnableWrite pulse, LastGrant=1.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin merge of two register-file write requesters into one write port
module reg_write_arbiter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   NReset,
  input  logic                   ValidA,
  input  logic [4:0]             IdA,
  input  logic [31:0]            DataA,
  output logic                   ReadyA,
  input  logic                   ValidB,
  input  logic [4:0]             IdB,
  input  logic [31:0]            DataB,
  output logic                   ReadyB,
  input  logic                   Hold,
  output logic                   EnableWrite,
  output logic [4:0]             RegIDToWrite,
  output logic [31:0]            DataIn,
  output logic [COUNT_WIDTH-1:0] WriteCount,
  output logic                   LastGrant
);
  logic                   en_q, en_d;
  logic [4:0]             id_q, id_d;
  logic [31:0]            data_q, data_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   hs;
  logic [4:0]             sel_id;
  // Grant: a lone requester wins; on contention the one not granted last time wins
  always_comb begin
    ReadyA = NReset & ~Hold & ValidA & (~ValidB | last_q);
    ReadyB = NReset & ~Hold & ValidB & (~ValidA | ~last_q);
    hs     = ReadyA | ReadyB;
    sel_id = ReadyA ? IdA : IdB;
    last_d = hs ? ReadyB : last_q;
    id_d   = hs ? sel_id : id_q;
    data_d = hs ? (ReadyA ? DataA : DataB) : data_q;
    en_d   = hs & (sel_id != 5'd0);
    cnt_d  = en_q ? cnt_q + 1'b1 : cnt_q;
  end
  // Capture the granted write; register 0 writes are accepted but never enabled
  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      en_q   <= 1'b0;
      id_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b1;
    end else begin
      en_q   <= en_d;
      id_q   <= id_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
  assign EnableWrite  = en_q;
  assign RegIDToWrite = id_q;
  assign DataIn       = data_q;
  assign WriteCount   = cnt_q;
  assign LastGrant    = last_q;
endmodule
